mux_n_pipe: RTL and testbench

//  Parametrised N-channel, WIDTH-bit selector with a registered output stage and valid/ready flow control.

---
 rtl/mux_n_pipe_pkg.sv | 18 +
 rtl/mux_n_comb.sv | 21 ++
 rtl/mux_n_pipe.sv | 136 +++++++++++++
 tb/tb_mux_n_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_n_pipe_pkg.sv
// Shared types and helpers for the pipelined N-channel selector.
package mux_n_pipe_pkg;

  localparam int unsigned MAX_WIDTH = 64;
  localparam logic [MAX_WIDTH-1:0] ZERO_DATA = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Select width for a given channel count; never below one bit.
  function automatic int unsigned sel_w_f(input int unsigned n_ch);
    return (n_ch < 2) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Combinational N_CH:1 selector; out-of-range selects yield all-zero data.
module mux_n_comb
  import mux_n_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_CH  = 3,
  localparam int unsigned SEL_W = sel_w_f(N_CH)
) (
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      data_c
);

  always_comb begin
    data_c = WIDTH'(ZERO_DATA);
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (sel == SEL_W'(k)) data_c = in_data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// Registered N-channel selector with valid/ready and a 2-entry skid buffer.
// Optional MUX_N_PIPE_SEL_CHECK_EN: drop out-of-range selects and raise sticky sel_err.
module mux_n_pipe
  import mux_n_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_CH  = 3,
  localparam int unsigned SEL_W = sel_w_f(N_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel
`ifdef MUX_N_PIPE_SEL_CHECK_EN
  ,
  output logic                  sel_err
`endif
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
  logic             in_ready_q, in_ready_d;

  logic [WIDTH-1:0] sel_data_c;
  logic             in_fire_c, out_fire_c, push_c;
  state_e           state_c;

  mux_n_comb #(.WIDTH(WIDTH), .N_CH(N_CH)) u_mux (
    .in_data (in_data),
    .sel     (in_sel),
    .data_c  (sel_data_c)
  );

  assign in_fire_c  = in_valid & in_ready_q;
  assign out_fire_c = out_valid_q & out_ready;

`ifdef MUX_N_PIPE_SEL_CHECK_EN
  logic sel_ok_c;
  logic sel_err_q, sel_err_d;

  assign sel_ok_c  = 32'(in_sel) < N_CH;
  assign push_c    = in_fire_c & sel_ok_c;
  assign sel_err_d = sel_err_q | (in_fire_c & ~sel_ok_c);
  assign sel_err   = sel_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sel_err_q <= 1'b0;
    else       sel_err_q <= sel_err_d;
  end
`else
  assign push_c = in_fire_c;
`endif

  // Occupancy decoded from the two valid flops.
  always_comb begin
    state_c = EMPTY;
    if (skid_valid_q)     state_c = FULL;
    else if (out_valid_q) state_c = ONE;
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_sel_d   = skid_sel_q;
    case (state_c)
      EMPTY: begin
        if (push_c) begin
          out_valid_d = 1'b1;
          out_data_d  = sel_data_c;
          out_sel_d   = in_sel;
        end
      end
      ONE: begin
        if (out_fire_c) begin
          out_valid_d = push_c;
          if (push_c) begin
            out_data_d = sel_data_c;
            out_sel_d  = in_sel;
          end
        end else if (push_c) begin
          skid_valid_d = 1'b1;
          skid_data_d  = sel_data_c;
          skid_sel_d   = in_sel;
        end
      end
      FULL: begin
        if (out_fire_c) begin
          out_data_d   = skid_data_q;
          out_sel_d    = skid_sel_q;
          skid_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_sel_q   <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_sel_q   <= skid_sel_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Scoreboard bench: a 32-bit/3-channel instance for directed cases, an 8-bit/5-channel one for random traffic.
module tb_mux_n_pipe;

  localparam int unsigned WA = 32, NA = 3, SA = 2;
  localparam int unsigned WB = 8,  NB = 5, SB = 3;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  sel;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [SA-1:0]    a_in_sel, a_out_sel;
  logic [NA*WA-1:0] a_in_data;
  logic [WA-1:0]    a_out_data;
  logic [WA-1:0]    a_ch [NA];

  logic             b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [SB-1:0]    b_in_sel, b_out_sel;
  logic [NB*WB-1:0] b_in_data;
  logic [WB-1:0]    b_out_data;
  logic [WB-1:0]    b_ch [NB];

`ifdef MUX_N_PIPE_SEL_CHECK_EN
  logic a_sel_err, b_sel_err;
`endif

  always_comb for (int k = 0; k < int'(NA); k++) a_in_data[k*WA +: WA] = a_ch[k];
  always_comb for (int k = 0; k < int'(NB); k++) b_in_data[k*WB +: WB] = b_ch[k];

  mux_n_pipe #(.WIDTH(WA), .N_CH(NA)) u_dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sel(a_in_sel), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_sel(a_out_sel)
`ifdef MUX_N_PIPE_SEL_CHECK_EN
    , .sel_err(a_sel_err)
`endif
  );

  mux_n_pipe #(.WIDTH(WB), .N_CH(NB)) u_dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sel(b_in_sel), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_sel(b_out_sel)
`ifdef MUX_N_PIPE_SEL_CHECK_EN
    , .sel_err(b_sel_err)
`endif
  );

  exp_t qa[$];
  exp_t qb[$];
  int   n_pass = 0;
  int   n_checks = 0;
  int   bp_sel [3] = '{2, 0, 1};
  logic b_err_exp = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Whether an accepted transfer with this select should reach the output.
  function automatic bit forwards(input int sel, input int n_ch);
`ifdef MUX_N_PIPE_SEL_CHECK_EN
    return sel < n_ch;
`else
    return 1'b1;
`endif
  endfunction

  // One cycle on A: caller sets in_valid/in_sel, task drives out_ready, scores, advances.
  task automatic step_a(input logic rdy, output logic acc);
    exp_t e;
    int   s;
    a_out_ready = rdy;
    acc = a_in_valid && a_in_ready;
    if (a_out_valid && rdy) begin
      if (qa.size() == 0) check("a_unexpected_out", 1, 0);
      else begin
        e = qa.pop_front();
        check("a_data", a_out_data, e.data);
        check("a_sel", 32'(a_out_sel), 32'(e.sel));
      end
    end
    s = int'(a_in_sel);
    if (acc && forwards(s, int'(NA))) begin
      e.sel  = 8'(a_in_sel);
      e.data = (s < int'(NA)) ? a_ch[s] : 32'h0;
      qa.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic rdy, output logic acc);
    exp_t e;
    int   s;
    b_out_ready = rdy;
    acc = b_in_valid && b_in_ready;
    if (b_out_valid && rdy) begin
      if (qb.size() == 0) check("b_unexpected_out", 1, 0);
      else begin
        e = qb.pop_front();
        check("b_data", 32'(b_out_data), e.data);
        check("b_sel", 32'(b_out_sel), 32'(e.sel));
      end
    end
    s = int'(b_in_sel);
    if (acc && s >= int'(NB)) b_err_exp = 1'b1;
    if (acc && forwards(s, int'(NB))) begin
      e.sel  = 8'(b_in_sel);
      e.data = (s < int'(NB)) ? 32'(b_ch[s]) : 32'h0;
      qb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic acc;
    int   accepted, idx, third_cyc;
    reset = 1'b1;
    a_in_valid = 0; a_in_sel = '0; a_out_ready = 0;
    b_in_valid = 0; b_in_sel = '0; b_out_ready = 0;
    a_ch[0] = 32'h11111111; a_ch[1] = 32'h22222222; a_ch[2] = 32'h33333333;
    for (int k = 0; k < int'(NB); k++) b_ch[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("in_ready_during_reset", a_in_ready, 1);
    reset = 1'b0;
    @(posedge clk); #1;

    check("rst_out_valid", a_out_valid, 0);
    check("rst_in_ready", a_in_ready, 1);
    check("rst_out_data", a_out_data, 0);
    check("rst_out_sel", 32'(a_out_sel), 0);
    check("rst_b_out_valid", b_out_valid, 0);
`ifdef MUX_N_PIPE_SEL_CHECK_EN
    check("rst_sel_err", a_sel_err, 0);
`endif

    // Streaming at full rate
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1; a_in_sel = SA'(i);
      step_a(1, acc);
      check("stream_accept", acc, 1);
      check("stream_latency", a_out_valid, 1);
    end
    a_in_valid = 0;
    step_a(1, acc);
    check("stream_drained", a_out_valid, 0);
    check("stream_q_empty", 32'(qa.size()), 0);

    // Backpressure: three offers against a stalled output
    accepted = 0; idx = 0;
    a_in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      a_in_sel = SA'(bp_sel[idx]);
      step_a(0, acc);
      if (acc) begin accepted++; idx++; end
    end
    check("bp_accepted", 32'(accepted), 2);
    check("bp_in_ready_low", a_in_ready, 0);
    check("bp_out_valid", a_out_valid, 1);

    // Stall stability: input data changes must not leak into a held output
    a_ch[0] = 32'hDEADBEEF; a_ch[1] = 32'hCAFEF00D; a_ch[2] = 32'h0BADC0DE;
    a_in_sel = SA'(bp_sel[idx]);
    repeat (2) step_a(0, acc);
    check("stall_data", a_out_data, qa[0].data);
    check("stall_sel", 32'(a_out_sel), 32'(qa[0].sel));
    check("stall_in_ready", a_in_ready, 0);

    third_cyc = -1;
    for (int i = 0; i < 10; i++) begin
      step_a(1, acc);
      if (acc) begin third_cyc = i; a_in_valid = 0; end
    end
    check("bp_third_accept_cycle", 32'(third_cyc), 1);
    check("bp_q_empty", 32'(qa.size()), 0);
    a_ch[0] = 32'h11111111; a_ch[1] = 32'h22222222; a_ch[2] = 32'h33333333;

    // Out-of-range select
    a_in_valid = 1; a_in_sel = 2'd3;
    step_a(1, acc);
    a_in_valid = 0;
    check("oor_accept", acc, 1);
`ifdef MUX_N_PIPE_SEL_CHECK_EN
    check("oor_no_out", a_out_valid, 0);
    check("oor_sel_err", a_sel_err, 1);
    repeat (3) step_a(1, acc);
    check("oor_sel_err_sticky", a_sel_err, 1);
`else
    check("oor_out_valid", a_out_valid, 1);
    check("oor_out_data", a_out_data, 0);
    check("oor_out_sel", 32'(a_out_sel), 3);
    step_a(1, acc);
`endif
    check("oor_q_empty", 32'(qa.size()), 0);

    // Asynchronous reset while FULL
    a_in_valid = 1; a_in_sel = 2'd0;
    step_a(0, acc);
    a_in_sel = 2'd1;
    step_a(0, acc);
    a_in_valid = 0;
    check("full_in_ready", a_in_ready, 0);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out_valid", a_out_valid, 0);
    check("async_rst_in_ready", a_in_ready, 1);
    check("async_rst_out_data", a_out_data, 0);
`ifdef MUX_N_PIPE_SEL_CHECK_EN
    check("async_rst_sel_err", a_sel_err, 0);
`endif
    qa.delete();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) step_a(1, acc);
    check("post_rst_no_stale", a_out_valid, 0);

    // Random traffic on the 8-bit, 5-channel instance
    acc = 0;
    for (int i = 0; i < 10000; i++) begin
      if (!b_in_valid || acc) begin
        b_in_valid = 1'($urandom_range(1));
        b_in_sel   = SB'($urandom_range(7));
        for (int k = 0; k < int'(NB); k++) b_ch[k] = WB'($urandom);
      end
      step_b(1'($urandom_range(1)), acc);
    end
    b_in_valid = 0;
    for (int i = 0; i < 20; i++) step_b(1, acc);
    check("rand_q_empty", 32'(qb.size()), 0);
    check("rand_out_idle", b_out_valid, 0);
`ifdef MUX_N_PIPE_SEL_CHECK_EN
    check("rand_sel_err", b_sel_err, b_err_exp);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
